// File: rtl/deser_frame_controller.sv
// ---------------------------------------------------------------------------
// deser_frame_controller
//
// Frame sequencer for the 1-to-14 deserializer. It synchronizes the
// active-low slave-select line, gates the enable of the external serial-in
// shift register for each received bit, counts bits (saturating), latches
// the parallel word into a holding register with a short/long frame flag,
// and runs a ready/ack handshake with the consumer. A frame that starts
// while an unacknowledged word is pending is dropped and raises a sticky
// overrun flag.
//
// State encoding is fixed so the debug state port is stable across builds:
//   IDLE=00, SHIFT=01, LOAD=11, DONE=10
// ---------------------------------------------------------------------------
module deser_frame_controller #(
    parameter int WIDTH       = 14,
    parameter int COUNT_W     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ss,
    input  logic               bit_valid,
    input  logic               ack,
    input  logic [WIDTH-1:0]   shift_q,
    output logic               shift_en,
    output logic [WIDTH-1:0]   data_out,
    output logic               ready,
    output logic               frame_err,
    output logic               overrun,
    output logic [COUNT_W-1:0] bit_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_LOAD  = 2'b11,
        ST_DONE  = 2'b10
    } state_e;

    // Counter comparison constants, sized to the counter width.
    localparam logic [COUNT_W-1:0] CNT_FULL = COUNT_W'(WIDTH);
    localparam logic [COUNT_W-1:0] CNT_SAT  = COUNT_W'(WIDTH + 1);
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ZERO = COUNT_W'(0);

    // Synchronizer chain and ss history (both reset to "deselected").
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ss_hist_q;
    logic                   ss_s;
    logic                   fall_s;
    logic                   rise_s;

    // FSM and datapath registers with their next-state values.
    state_e             state_q,     state_d;
    logic [COUNT_W-1:0] bit_count_q, bit_count_d;
    logic [WIDTH-1:0]   data_q,      data_d;
    logic               err_q,       err_d;
    logic               ovr_q,       ovr_d;
    logic               ready_q,     ready_d;
    logic               shift_en_s;

    assign ss_s   = sync_q[SYNC_STAGES-1];
    assign fall_s = ss_hist_q & ~ss_s;
    assign rise_s = ~ss_hist_q & ss_s;

    // Bring the asynchronous ss into the clock domain and keep one cycle of history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '1;
            ss_hist_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ss};
            ss_hist_q <= ss_s;
        end
    end

    // Next-state, counter, latch and flag logic for the frame FSM.
    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        data_d      = data_q;
        err_d       = err_q;
        ovr_d       = ovr_q;
        shift_en_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // bit_valid has no effect until a frame has started.
                if (fall_s) begin
                    state_d     = ST_SHIFT;
                    bit_count_d = CNT_ZERO;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                // Stop shifting after WIDTH bits so a long frame keeps its first bits.
                shift_en_s = bit_valid & (bit_count_q < CNT_FULL);
                if (bit_valid && (bit_count_q < CNT_SAT)) begin
                    bit_count_d = bit_count_q + CNT_ONE;
                end else begin
                    bit_count_d = bit_count_q;
                end
                // A bit arriving together with the rise is still shifted and counted above.
                if (rise_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end

            ST_LOAD: begin
                data_d  = shift_q;
                err_d   = (bit_count_q != CNT_FULL);
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (ack) begin
                    if (fall_s) begin
                        // Consumer freed the slot in the same cycle: start directly.
                        state_d     = ST_SHIFT;
                        bit_count_d = CNT_ZERO;
                    end else begin
                        state_d     = ST_IDLE;
                    end
                end else if (fall_s) begin
                    // Word still pending: the new frame is dropped, never shifted.
                    ovr_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_DONE);
    end

    // State, counter, holding register and flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_count_q <= CNT_ZERO;
            data_q      <= '0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            data_q      <= data_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            ready_q     <= ready_d;
        end
    end

    assign shift_en  = shift_en_s;
    assign data_out  = data_q;
    assign ready     = ready_q;
    assign frame_err = err_q;
    assign overrun   = ovr_q;
    assign bit_count = bit_count_q;
    assign state     = state_q;

endmodule

// File: doc/deser_frame_controller.md
Name: deser_frame_controller

Overview:
- Sequences the 14-bit serial-in shift register (ShiftRegisterWEnableFourteen) used by the 1-to-14 deserializer.
- Detects frame start and end on the slave-select line and gates the shift enable per received bit.
- Counts bits, flags short/long frames and latches the parallel word into a holding register.
- Runs a ready/ack handshake with the consumer and flags frames that start while an unacknowledged word is pending.

Parameters:
- WIDTH, 14, frame length in bits; must match the shift register width.
- COUNT_W, 4, bit counter width; must satisfy 2^COUNT_W > WIDTH+1.
- SYNC_STAGES, 2, ss synchronizer depth; minimum 2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ss  in  1  active-low frame select; asynchronous to clock, synchronized internally.
- bit_valid  in  1  synchronous one-cycle strobe: a serial bit is present on the shift register's d input this cycle.
- ack  in  1  consumer acknowledges data_out.
- shift_q  in  WIDTH  parallel output of the shift register.
- shift_en  out  1  shift register enable.
- data_out  out  WIDTH  holding register; stable while ready=1.
- ready  out  1  word available.
- frame_err  out  1  latched frame has a bit count other than WIDTH; valid while ready=1.
- overrun  out  1  sticky; a frame started while in DONE.
- bit_count  out  COUNT_W  debug: current bit counter.
- state  out  2  debug: current FSM state.

Behaviour:
- Reset values: state=IDLE, bit_count=0, data_out=0, ready=0, frame_err=0, overrun=0, shift_en=0.
- Reset also presets every synchronizer stage and the ss history register to 1 (deselected).
- Reset asserted mid-frame aborts the frame; no word is latched.
- Synchronization: ss passes through SYNC_STAGES flops to give ss_s; ss_d is ss_s delayed one clock.
- Edge detect: fall = ss_d & ~ss_s; rise = ~ss_d & ss_s. Both are single-cycle and mutually exclusive.
- Encodings: IDLE=2'b00, SHIFT=2'b01, LOAD=2'b11, DONE=2'b10.
- IDLE:
  - fall -> SHIFT, bit_count<=0.
  - bit_valid is ignored.
- SHIFT:
  - shift_en = bit_valid & (bit_count < WIDTH). This is combinational; it is 0 in every other state.
  - On bit_valid, bit_count increments, saturating at WIDTH+1.
  - rise -> LOAD. A bit_valid in the same cycle as rise is shifted and counted.
- LOAD (exactly one cycle):
  - data_out<=shift_q.
  - frame_err<=(bit_count != WIDTH).
  - -> DONE.
- DONE:
  - ready=1; data_out and frame_err are held.
  - ack & ~fall -> IDLE.
  - ack & fall -> SHIFT with bit_count<=0; no overrun.
  - ~ack & fall -> overrun<=1, stay DONE; that frame is dropped entirely, with no shifting.
- ack outside DONE is ignored.
- overrun clears only on reset.
- Short frame (bit_count<WIDTH): the shift register holds stale upper bits. The word is still latched, with frame_err=1.
- Long frame: shifting stops after WIDTH bits, so the first WIDTH bits are kept. frame_err=1.
- Zero-bit frame (fall then rise, no bit_valid): latched with frame_err=1.
- Latency: raw ss rise sampled at clock edge k gives ready=1 after edge k+SYNC_STAGES+1. ack sampled high at an edge drops ready after that edge.
- Glitch rule: ss pulses shorter than one clock may be missed. No minimum ss high time is guaranteed beyond 2 clocks.

Test Plan:
- Nominal frame: reset, ss low, 14 bit_valid strobes of 0b10110011100101 MSB first, ss high -> shift_en pulses exactly 14 times. ready rises SYNC_STAGES+1 cycles after raw ss rise. data_out=14'h2CE5, frame_err=0. ack -> ready=0, state=IDLE.
- Short frame: 9 strobes then ss high -> ready=1, frame_err=1, bit_count=9.
- Long frame: 17 strobes -> shift_en high for the first 14 only. bit_count saturates at 15. frame_err=1, data_out = first 14 bits.
- Overrun: hold ack low in DONE, drive a full second frame -> overrun=1, data_out unchanged, no shift_en pulses. Then ack -> IDLE, overrun remains 1.
- Back-to-back: ack asserted in the same cycle as a synchronized ss fall -> state goes DONE->SHIFT directly. Second word received correctly, overrun=0.
- Async reset mid-SHIFT after 7 bits -> all outputs return to their reset values immediately. A subsequent full frame is received correctly with frame_err=0.
